bcd_game_timer: RTL and testbench
=================================

Name: bcd_game_timer

Overview:
- Parametrised N-digit BCD game timer; successor to the fixed two-digit count-up game counter.
- Counts up or down at one step per CLOCK_FREQUENCY clocks.
- Supports preload, start, pause/resume, clear, and terminal-count detection.
- Sits between the game control FSM (start/pause/clear, done) and the HEX display/score logic, which consume the packed BCD digits.

Parameters:
- CLOCK_FREQUENCY, 50000000: input clock cycles per timer step; must be >= 2.
- DIGITS, 2: number of BCD digits; must be >= 1. Value width is 4*DIGITS.

Ports:
- ClockIn  in  1  system clock; all logic on rising edge.
- Resetn  in  1  synchronous, active-low reset.
- Clear  in  1  synchronous abort: value to 0, state to IDLE.
- Load  in  1  preload LoadValue; honoured in IDLE or EXPIRED only.
- LoadValue  in  4*DIGITS  packed BCD preload; digit 0 is in bits [3:0].
- CountDown  in  1  direction: 1 counts down, 0 counts up. Sampled only on the Start edge.
- Start  in  1  begin counting; honoured in IDLE only.
- Pause  in  1  level input; high holds the count while running.
- BcdValue  out  4*DIGITS  current packed BCD value.
- Running  out  1  high in RUN.
- Expired  out  1  high in EXPIRED.
- Done  out  1  one-cycle pulse on reaching terminal count.

Behaviour:
Reset and priority:
- Resetn low at a clock edge: state=IDLE, BcdValue=0, Running=0, Expired=0, Done=0, direction latch=0 (up), prescaler=CLOCK_FREQUENCY-1.
- Priority per edge: Resetn > Clear > Load > Start > Pause > tick.

State machine (IDLE, RUN, PAUSED, EXPIRED):
- IDLE
  - Load: BcdValue<=LoadValue, with any digit >9 clamped to 9.
  - Start: latch CountDown, prescaler<=CLOCK_FREQUENCY-1, go RUN.
- RUN
  - Pause high: go PAUSED. Prescaler and value are frozen that edge.
  - Otherwise prescaler decrements each cycle.
  - When the prescaler is 0: reload it to CLOCK_FREQUENCY-1 and step the value.
  - First step lands exactly CLOCK_FREQUENCY edges after the edge that entered RUN.
- PAUSED
  - Pause low: return to RUN. Prescaler resumes from its held value, with no lost or extra cycles.
  - Start and Load are ignored.
- EXPIRED
  - Value holds.
  - Load: reload value, go IDLE.
  - Start: ignored until a Load or Clear.
- Clear from any state: BcdValue<=0, go IDLE, Done=0.

Arithmetic:
- Up step: BCD increment with ripple carry; a digit at 9 wraps to 0 and carries.
- Down step: BCD decrement with ripple borrow; a digit at 0 wraps to 9 and borrows.
- Terminal count: all digits 9 (up) or all digits 0 (down).
- The step that produces the terminal value also moves the state to EXPIRED on the same edge.
- Done is registered: high for exactly the one cycle in which BcdValue first shows the terminal value.
- If the value is already terminal when Start is honoured, the next edge goes to EXPIRED with Done=1 and the value unchanged (no wrap).

Outputs and boundary cases:
- BcdValue, Running, Expired and Done are all registered; none is combinational from inputs.
- Clear or Resetn in the same cycle as a tick: the reset/clear wins and no step occurs.
- Pause asserted in the same cycle as prescaler==0: no step; the step happens on the first RUN cycle after resume.
- CountDown changes while running are ignored.

Decomposition:
- Shared package game_timer_pkg holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, EXPIRED=2'd3
  - BCD_MAX=4'd9
  - helper function computing prescaler width as $clog2(CLOCK_FREQUENCY)
- One natural sub-module: tick_prescaler, a reloadable down-counter with enable/hold that outputs a one-cycle tick.
- Digit stepping is a generate loop over DIGITS inside the top module.
- The display decoder stays external.

Test Plan (CLOCK_FREQUENCY=4, DIGITS=2 unless noted):
1. Count up: Resetn low 2 cycles; Start with CountDown=0.
   -> BcdValue reads 0x01 4 edges after RUN entry, 0x09 at 36, 0x10 at 40.
   -> 0x99 at edge 396 with Done=1 for 1 cycle, Expired=1.
2. Countdown: Load 0x12 in IDLE, Start with CountDown=1.
   -> 0x11, 0x10, 0x09 every 4 edges; 0x00 after 48 edges with Done pulse; then held in EXPIRED.
3. Pause: running up at value 0x05; Pause high for 10 cycles, then low.
   -> value stays 0x05 throughout.
   -> next step arrives after exactly the remaining prescaler cycles; total count cycles excluding paused cycles equal 4 per step.
4. Preload clamp and terminal start: Load 0xAF.
   -> BcdValue=0x99.
   -> Start up: next edge Expired=1, Done=1 pulse, value stays 0x99; a further Start is ignored.
5. Mid-run abort: Clear and a tick coincide at value 0x37.
   -> BcdValue=0x00, state IDLE, Done=0. Resetn low mid-RUN gives all outputs 0 on that edge.
6. DIGITS=3, count down from Load 0x100.
   -> next value 0x099, borrow across two digits correct; terminal at 0x000 after 400 edges.

Source files
------------

// File: rtl/game_timer_pkg.sv
// Shared types and helpers for the N-digit BCD game timer.
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic int prescaler_width(input int clock_frequency);
    return $clog2(clock_frequency);
  endfunction

  // Out-of-range preload digits saturate rather than wrap.
  function automatic logic [3:0] clamp_digit(input logic [3:0] digit);
    if (digit > BCD_MAX) begin
      return BCD_MAX;
    end else begin
      return digit;
    end
  endfunction

endpackage

// File: rtl/bcd_game_timer_checker.sv
// Structural invariants of the timer outputs, kept out of the datapath.
module bcd_game_timer_checker #(
  parameter int DIGITS = 2
) (
  input logic                  ClockIn,
  input logic                  Resetn,
  input logic [4*DIGITS-1:0]   BcdValue,
  input logic                  Running,
  input logic                  Expired,
  input logic                  Done
);

  a_done_implies_expired: assert property (
    @(posedge ClockIn) disable iff (!Resetn) Done |-> Expired);

  a_running_excludes_expired: assert property (
    @(posedge ClockIn) disable iff (!Resetn) !(Running && Expired));

  a_done_single_cycle: assert property (
    @(posedge ClockIn) disable iff (!Resetn) Done |=> !Done);

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit_check
    a_digit_is_bcd: assert property (
      @(posedge ClockIn) disable iff (!Resetn) BcdValue[4*i +: 4] <= 4'd9);
  end

endmodule

// File: rtl/bcd_game_timer_tick_prescaler.sv
// Reloadable down-counter: Tick is high for the one enabled cycle in which the count is zero.
module tick_prescaler
  import game_timer_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000
) (
  input  logic ClockIn,
  input  logic Resetn,
  input  logic Reload,
  input  logic Enable,
  output logic Tick
);

  localparam int WIDTH = prescaler_width(CLOCK_FREQUENCY);
  localparam logic [WIDTH-1:0] RELOAD_VALUE = WIDTH'(CLOCK_FREQUENCY - 1);
  localparam logic [WIDTH-1:0] ONE          = WIDTH'(1);

  logic [WIDTH-1:0] count_r;

  // Count down while enabled, wrap to the reload value on zero, hold otherwise.
  always_ff @(posedge ClockIn) begin
    if (!Resetn) begin
      count_r <= RELOAD_VALUE;
    end else if (Reload) begin
      count_r <= RELOAD_VALUE;
    end else if (Enable) begin
      count_r <= (count_r == '0) ? RELOAD_VALUE : (count_r - ONE);
    end else begin
      count_r <= count_r;
    end
  end

  assign Tick = Enable && (count_r == '0);

endmodule

// File: rtl/bcd_game_timer.sv
// N-digit BCD up/down game timer with preload, pause, clear and terminal-count pulse.
module bcd_game_timer
  import game_timer_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int DIGITS          = 2
) (
  input  logic                ClockIn,
  input  logic                Resetn,
  input  logic                Clear,
  input  logic                Load,
  input  logic [4*DIGITS-1:0] LoadValue,
  input  logic                CountDown,
  input  logic                Start,
  input  logic                Pause,
  output logic [4*DIGITS-1:0] BcdValue,
  output logic                Running,
  output logic                Expired,
  output logic                Done
);

  timer_state_t        state_r;
  logic [4*DIGITS-1:0] value_r;
  logic                count_down_r;
  logic                running_r;
  logic                expired_r;
  logic                done_r;

  logic [4*DIGITS-1:0] step_value_s;
  logic [4*DIGITS-1:0] load_value_s;
  logic [DIGITS-1:0]   digit_max_s;
  logic [DIGITS-1:0]   digit_min_s;
  logic [DIGITS-1:0]   step_max_s;
  logic [DIGITS-1:0]   step_min_s;
  logic                value_terminal_s;
  logic                step_terminal_s;
  logic                presc_reload_s;
  logic                presc_enable_s;
  logic                tick_s;

  // Each digit steps when every lower digit is at its wrap point, so no ripple chain is needed.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] digit_s;
    logic [3:0] step_digit_s;
    logic       step_in_s;

    assign digit_s        = value_r[4*i +: 4];
    assign digit_max_s[i] = (digit_s == BCD_MAX);
    assign digit_min_s[i] = (digit_s == 4'd0);

    if (i == 0) begin : g_lsd
      assign step_in_s = 1'b1;
    end else begin : g_upper
      assign step_in_s = count_down_r ? (&digit_min_s[i-1:0]) : (&digit_max_s[i-1:0]);
    end

    // Single-digit BCD increment/decrement with wrap.
    always_comb begin
      step_digit_s = digit_s;
      if (!step_in_s) begin
        step_digit_s = digit_s;
      end else if (count_down_r) begin
        step_digit_s = (digit_s == 4'd0) ? BCD_MAX : (digit_s - 4'd1);
      end else begin
        step_digit_s = (digit_s == BCD_MAX) ? 4'd0 : (digit_s + 4'd1);
      end
    end

    assign step_value_s[4*i +: 4] = step_digit_s;
    assign step_max_s[i]          = (step_digit_s == BCD_MAX);
    assign step_min_s[i]          = (step_digit_s == 4'd0);
    assign load_value_s[4*i +: 4] = clamp_digit(LoadValue[4*i +: 4]);
  end

  assign value_terminal_s = count_down_r ? (&digit_min_s) : (&digit_max_s);
  assign step_terminal_s  = count_down_r ? (&step_min_s)  : (&step_max_s);

  // The prescaler sits at its reload value whenever the timer is not counting.
  assign presc_reload_s = Clear || (state_r == IDLE) || (state_r == EXPIRED);
  assign presc_enable_s = (state_r == RUN) && !Pause && !value_terminal_s;

  tick_prescaler #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
  ) u_prescaler (
    .ClockIn (ClockIn),
    .Resetn  (Resetn),
    .Reload  (presc_reload_s),
    .Enable  (presc_enable_s),
    .Tick    (tick_s)
  );

  // Timer state machine with registered value and status outputs.
  always_ff @(posedge ClockIn) begin
    if (!Resetn) begin
      state_r      <= IDLE;
      value_r      <= '0;
      count_down_r <= 1'b0;
      running_r    <= 1'b0;
      expired_r    <= 1'b0;
      done_r       <= 1'b0;
    end else if (Clear) begin
      state_r   <= IDLE;
      value_r   <= '0;
      running_r <= 1'b0;
      expired_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (Load) begin
            value_r <= load_value_s;
          end else if (Start) begin
            count_down_r <= CountDown;
            state_r      <= RUN;
            running_r    <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (Pause) begin
            state_r   <= PAUSED;
            running_r <= 1'b0;
          end else if (value_terminal_s) begin
            // Started on an already-terminal value: expire without wrapping.
            state_r   <= EXPIRED;
            running_r <= 1'b0;
            expired_r <= 1'b1;
            done_r    <= 1'b1;
          end else if (tick_s) begin
            value_r <= step_value_s;
            if (step_terminal_s) begin
              state_r   <= EXPIRED;
              running_r <= 1'b0;
              expired_r <= 1'b1;
              done_r    <= 1'b1;
            end else begin
              state_r <= RUN;
            end
          end else begin
            state_r <= RUN;
          end
        end
        PAUSED: begin
          if (!Pause) begin
            state_r   <= RUN;
            running_r <= 1'b1;
          end else begin
            state_r <= PAUSED;
          end
        end
        EXPIRED: begin
          if (Load) begin
            value_r   <= load_value_s;
            state_r   <= IDLE;
            expired_r <= 1'b0;
          end else begin
            state_r <= EXPIRED;
          end
        end
        default: begin
          state_r   <= IDLE;
          running_r <= 1'b0;
          expired_r <= 1'b0;
        end
      endcase
    end
  end

  assign BcdValue = value_r;
  assign Running  = running_r;
  assign Expired  = expired_r;
  assign Done     = done_r;

  bcd_game_timer_checker #(
    .DIGITS(DIGITS)
  ) u_checker (
    .ClockIn  (ClockIn),
    .Resetn   (Resetn),
    .BcdValue (value_r),
    .Running  (running_r),
    .Expired  (expired_r),
    .Done     (done_r)
  );

endmodule

// File: tb/tb_bcd_game_timer.sv
// Directed bench for bcd_game_timer: two-digit and three-digit instances at CLOCK_FREQUENCY=4.
module tb_bcd_game_timer;

  logic        clock;
  logic        resetn;
  logic        clear;
  logic        count_down;
  logic        start;
  logic        pause;
  logic        load;
  logic [7:0]  load_value;
  logic [7:0]  bcd_value;
  logic        running;
  logic        expired;
  logic        done;
  logic        load3;
  logic [11:0] load_value3;
  logic [11:0] bcd_value3;
  logic        running3;
  logic        expired3;
  logic        done3;

  int n_checks;
  int n_fail;

  bcd_game_timer #(.CLOCK_FREQUENCY(4), .DIGITS(2)) dut (
    .ClockIn(clock), .Resetn(resetn), .Clear(clear), .Load(load), .LoadValue(load_value),
    .CountDown(count_down), .Start(start), .Pause(pause),
    .BcdValue(bcd_value), .Running(running), .Expired(expired), .Done(done)
  );

  bcd_game_timer #(.CLOCK_FREQUENCY(4), .DIGITS(3)) dut3 (
    .ClockIn(clock), .Resetn(resetn), .Clear(clear), .Load(load3), .LoadValue(load_value3),
    .CountDown(count_down), .Start(start), .Pause(pause),
    .BcdValue(bcd_value3), .Running(running3), .Expired(expired3), .Done(done3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
  endtask

  task automatic do_start(input logic dir);
    count_down = dir;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bcd_value !== 8'h00) begin n_fail++; $display("FAIL reset_value got %h want 00", bcd_value); end
    n_checks++;
    if ({running, expired, done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {running, expired, done}); end
  endtask

  task automatic test_count_up();
    do_reset();
    do_start(1'b0);
    n_checks++;
    if (running !== 1'b1 || bcd_value !== 8'h00) begin n_fail++; $display("FAIL up_enter got run=%b val=%h want 1/00", running, bcd_value); end
    tick(4);
    n_checks++;
    if (bcd_value !== 8'h01) begin n_fail++; $display("FAIL up_edge4 got %h want 01", bcd_value); end
    tick(32);
    n_checks++;
    if (bcd_value !== 8'h09) begin n_fail++; $display("FAIL up_edge36 got %h want 09", bcd_value); end
    tick(4);
    n_checks++;
    if (bcd_value !== 8'h10) begin n_fail++; $display("FAIL up_edge40 got %h want 10", bcd_value); end
    tick(355);
    n_checks++;
    if (bcd_value !== 8'h98 || done !== 1'b0) begin n_fail++; $display("FAIL up_edge395 got val=%h done=%b want 98/0", bcd_value, done); end
    tick(1);
    n_checks++;
    if ({bcd_value, done, expired, running} !== {8'h99, 3'b110}) begin
      n_fail++; $display("FAIL up_terminal got val=%h done=%b exp=%b run=%b want 99/1/1/0", bcd_value, done, expired, running);
    end
    tick(1);
    n_checks++;
    if ({bcd_value, done, expired} !== {8'h99, 2'b01}) begin n_fail++; $display("FAIL up_done_pulse got val=%h done=%b exp=%b want 99/0/1", bcd_value, done, expired); end
    do_start(1'b0);
    tick(5);
    n_checks++;
    if ({bcd_value, expired, running} !== {8'h99, 2'b10}) begin n_fail++; $display("FAIL up_start_in_expired got val=%h exp=%b run=%b want 99/1/0", bcd_value, expired, running); end
  endtask

  task automatic test_count_down();
    do_reset();
    load = 1'b1; load_value = 8'h12;
    tick(1);
    load = 1'b0;
    n_checks++;
    if (bcd_value !== 8'h12) begin n_fail++; $display("FAIL down_load got %h want 12", bcd_value); end
    do_start(1'b1);
    count_down = 1'b0;
    tick(4);
    n_checks++;
    if (bcd_value !== 8'h11) begin n_fail++; $display("FAIL down_step1 got %h want 11", bcd_value); end
    tick(4);
    n_checks++;
    if (bcd_value !== 8'h10) begin n_fail++; $display("FAIL down_step2 got %h want 10", bcd_value); end
    tick(4);
    n_checks++;
    if (bcd_value !== 8'h09) begin n_fail++; $display("FAIL down_borrow got %h want 09", bcd_value); end
    tick(35);
    n_checks++;
    if (bcd_value !== 8'h01 || done !== 1'b0) begin n_fail++; $display("FAIL down_edge47 got val=%h done=%b want 01/0", bcd_value, done); end
    tick(1);
    n_checks++;
    if ({bcd_value, done, expired} !== {8'h00, 2'b11}) begin n_fail++; $display("FAIL down_terminal got val=%h done=%b exp=%b want 00/1/1", bcd_value, done, expired); end
    tick(5);
    n_checks++;
    if ({bcd_value, done, expired} !== {8'h00, 2'b01}) begin n_fail++; $display("FAIL down_hold got val=%h done=%b exp=%b want 00/0/1", bcd_value, done, expired); end
  endtask

  task automatic test_pause();
    do_reset();
    do_start(1'b0);
    tick(22);
    n_checks++;
    if (bcd_value !== 8'h05) begin n_fail++; $display("FAIL pause_pre got %h want 05", bcd_value); end
    pause = 1'b1;
    tick(1);
    n_checks++;
    if (running !== 1'b0 || bcd_value !== 8'h05) begin n_fail++; $display("FAIL pause_enter got run=%b val=%h want 0/05", running, bcd_value); end
    tick(9);
    n_checks++;
    if (bcd_value !== 8'h05) begin n_fail++; $display("FAIL pause_hold got %h want 05", bcd_value); end
    pause = 1'b0;
    tick(1);
    n_checks++;
    if (running !== 1'b1 || bcd_value !== 8'h05) begin n_fail++; $display("FAIL pause_resume got run=%b val=%h want 1/05", running, bcd_value); end
    tick(1);
    n_checks++;
    if (bcd_value !== 8'h05) begin n_fail++; $display("FAIL pause_no_early got %h want 05", bcd_value); end
    tick(1);
    n_checks++;
    if (bcd_value !== 8'h06) begin n_fail++; $display("FAIL pause_step got %h want 06", bcd_value); end
    // Pause on the very cycle the prescaler reaches zero.
    tick(3);
    pause = 1'b1;
    tick(1);
    pause = 1'b0;
    tick(1);
    n_checks++;
    if (bcd_value !== 8'h06 || running !== 1'b1) begin n_fail++; $display("FAIL pause_at_zero got val=%h run=%b want 06/1", bcd_value, running); end
    tick(1);
    n_checks++;
    if (bcd_value !== 8'h07) begin n_fail++; $display("FAIL pause_zero_step got %h want 07", bcd_value); end
  endtask

  task automatic test_clamp_terminal();
    do_reset();
    load = 1'b1; load_value = 8'hAF;
    tick(1);
    load = 1'b0;
    n_checks++;
    if (bcd_value !== 8'h99) begin n_fail++; $display("FAIL clamp got %h want 99", bcd_value); end
    do_start(1'b0);
    tick(1);
    n_checks++;
    if ({bcd_value, done, expired} !== {8'h99, 2'b11}) begin n_fail++; $display("FAIL terminal_start got val=%h done=%b exp=%b want 99/1/1", bcd_value, done, expired); end
    do_start(1'b0);
    n_checks++;
    if ({bcd_value, done, expired, running} !== {8'h99, 3'b010}) begin n_fail++; $display("FAIL terminal_restart got val=%h done=%b exp=%b run=%b want 99/0/1/0", bcd_value, done, expired, running); end
    load = 1'b1; load_value = 8'h3C;
    tick(1);
    load = 1'b0;
    n_checks++;
    if ({bcd_value, expired} !== {8'h39, 1'b0}) begin n_fail++; $display("FAIL expired_reload got val=%h exp=%b want 39/0", bcd_value, expired); end
  endtask

  task automatic test_abort();
    do_reset();
    load = 1'b1; load_value = 8'h37;
    tick(1);
    load = 1'b0;
    do_start(1'b0);
    tick(3);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    n_checks++;
    if ({bcd_value, running, expired, done} !== {8'h00, 3'b000}) begin
      n_fail++; $display("FAIL clear_vs_tick got val=%h run=%b exp=%b done=%b want 00/0/0/0", bcd_value, running, expired, done);
    end
    tick(8);
    n_checks++;
    if (bcd_value !== 8'h00 || running !== 1'b0) begin n_fail++; $display("FAIL clear_idle got val=%h run=%b want 00/0", bcd_value, running); end
    do_start(1'b0);
    tick(6);
    resetn = 1'b0;
    tick(1);
    n_checks++;
    if ({bcd_value, running, expired, done} !== {8'h00, 3'b000}) begin
      n_fail++; $display("FAIL reset_mid_run got val=%h run=%b exp=%b done=%b want 00/0/0/0", bcd_value, running, expired, done);
    end
    resetn = 1'b1;
  endtask

  task automatic test_digits3();
    do_reset();
    load3 = 1'b1; load_value3 = 12'h100;
    tick(1);
    load3 = 1'b0;
    n_checks++;
    if (bcd_value3 !== 12'h100) begin n_fail++; $display("FAIL d3_load got %h want 100", bcd_value3); end
    do_start(1'b1);
    tick(4);
    n_checks++;
    if (bcd_value3 !== 12'h099) begin n_fail++; $display("FAIL d3_borrow got %h want 099", bcd_value3); end
    tick(4);
    n_checks++;
    if (bcd_value3 !== 12'h098) begin n_fail++; $display("FAIL d3_step2 got %h want 098", bcd_value3); end
    tick(391);
    n_checks++;
    if (bcd_value3 !== 12'h001 || done3 !== 1'b0) begin n_fail++; $display("FAIL d3_edge399 got val=%h done=%b want 001/0", bcd_value3, done3); end
    tick(1);
    n_checks++;
    if ({bcd_value3, done3, expired3} !== {12'h000, 2'b11}) begin n_fail++; $display("FAIL d3_terminal got val=%h done=%b exp=%b want 000/1/1", bcd_value3, done3, expired3); end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    resetn      = 1'b0;
    clear       = 1'b0;
    count_down  = 1'b0;
    start       = 1'b0;
    pause       = 1'b0;
    load        = 1'b0;
    load_value  = 8'h00;
    load3       = 1'b0;
    load_value3 = 12'h000;
    test_reset();
    test_count_up();
    test_count_down();
    test_pause();
    test_clamp_terminal();
    test_abort();
    test_digits3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
